// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory among NUM_REQ requesters
// One transaction outstanding at a time; a bounded BUSY wait turns a silent memory into an error ack.
module mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [NUM_REQ-1:0]            req_err_o,
  output logic [WIDTH-1:0]              req_rdata_o,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          mem_valid_o,
  output logic                          mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]              mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [WIDTH-1:0]              mem_rdata_i
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [GW-1:0]        last_grant;
  logic [CW-1:0]        cnt;
  logic                 found;
  logic [GW-1:0]        winner;
  logic [GW-1:0]        cand;
  logic [NUM_REQ-1:0]   onehot;

  // Search from the requester after the last one served, so it ends up lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    onehot             = '0;
    onehot[grant_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_grant  <= GW'(NUM_REQ - 1);
      cnt         <= '0;
      req_ack_o   <= '0;
      req_err_o   <= '0;
      req_rdata_o <= '0;
      busy_o      <= 1'b0;
      grant_id_o  <= '0;
      mem_valid_o <= 1'b0;
      mem_wr_rd_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            mem_valid_o <= 1'b1;
            mem_wr_rd_o <= req_wr_rd_i[winner];
            mem_addr_o  <= req_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o <= req_wdata_i[int'(winner)*WIDTH +: WIDTH];
            grant_id_o  <= winner;
            last_grant  <= winner;
            cnt         <= '0;
            busy_o      <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // Ready takes precedence over a timeout landing in the same cycle.
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            req_rdata_o <= mem_wr_rd_o ? '0 : mem_rdata_i;
            req_ack_o   <= onehot;
            state       <= DONE;
          end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
            mem_valid_o <= 1'b0;
            req_rdata_o <= '0;
            req_ack_o   <= onehot;
            req_err_o   <= onehot;
            state       <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          req_ack_o <= '0;
          req_err_o <= '0;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port memory (valid/ready, wr_rd, addr, wdata, rdata) between NUM_REQ requesters. It sits between the requester BFMs or masters and the memory interface. It serialises transactions, one outstanding at a time. A bounded wait turns a memory that never asserts ready into an error response instead of a hang.

## Interface
- NUM_REQ, 2: number of requesters; legal 2..8.
- WIDTH, 16: data width.
- DEPTH, 64: memory depth in words.
- ADDR_WIDTH, $clog2(DEPTH) = 6: address width.
- TIMEOUT, 16: maximum BUSY cycles without mem_ready_i; 0 disables the timeout.
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  NUM_REQ  per-requester request.
- req_wr_rd_i  input  NUM_REQ  per-requester direction; 1 = write, 0 = read.
- req_addr_i  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata_i  input  NUM_REQ*WIDTH  flattened write data; same packing.
- req_ack_o  output  NUM_REQ  one-cycle completion pulse, one-hot.
- req_err_o  output  NUM_REQ  timeout flag; valid only with req_ack_o.
- req_rdata_o  output  WIDTH  read data, shared by all requesters; valid with req_ack_o for reads.
- busy_o  output  1  high in BUSY and DONE.
- grant_id_o  output  $clog2(NUM_REQ)  index of the current/last granted requester.
- mem_valid_o  output  1  memory request.
- mem_wr_rd_o  output  1  memory direction.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_wdata_o  output  WIDTH  memory write data.
- mem_ready_i  input  1  memory completion.
- mem_rdata_i  input  WIDTH  memory read data; valid while mem_ready_i = 1.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- IDLE: if any req_valid_i is set, pick a winner round-robin.
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - Register the winner's wr_rd/addr/wdata onto mem_*_o and set mem_valid_o.
  - Load grant_id_o and last_grant with the winner; clear the timeout counter; go to BUSY.
  - If no request is present, stay in IDLE.
- BUSY: mem_valid_o = 1. mem_wr_rd_o, mem_addr_o and mem_wdata_o are held stable.
  - mem_ready_i = 1: clear mem_valid_o. For a read, register mem_rdata_i into req_rdata_o; for a write, req_rdata_o = 0. Set req_ack_o[grant] and go to DONE.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1: clear mem_valid_o, req_rdata_o = 0, set req_ack_o[grant] and req_err_o[grant], and go to DONE.
  - Else increment the counter. Its width is $clog2(TIMEOUT+1), and it saturates.
- DONE: req_ack_o (and req_err_o if set) is high for exactly this cycle.
  - Both clear on the exit to IDLE.
  - No arbitration happens in DONE.
- Requester rules:
  - Hold req_valid_i and its fields stable from assertion until ack.
  - On the cycle after ack, either deassert req_valid_i or present the next request.
  - The arbiter ignores requester field changes outside IDLE.
- Fairness: the requester just served has lowest priority at the next arbitration. With all NUM_REQ requesters continuously requesting, each is served once per NUM_REQ transactions.
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - Counter 0.
- Reset mid-transaction: the next edge forces IDLE and all outputs 0. The outstanding memory access is abandoned with no ack.
- mem_ready_i is ignored outside BUSY.

## Timing
- Cycle 0: IDLE samples req_valid_i. Cycle 1: mem_valid_o = 1.
- If mem_ready_i is first high in cycle k ≥ 1, req_ack_o is high in cycle k+1 (DONE) and IDLE is in cycle k+2.
- Minimum transaction: 3 cycles (IDLE, BUSY with immediate ready, DONE). Back-to-back throughput is one transaction per 3 cycles.
- Timeout: with mem_ready_i never high, mem_valid_o is high for exactly TIMEOUT cycles, then ack+err in the following cycle.
- A mem_ready_i in the same cycle the counter hits TIMEOUT-1 completes normally: ready wins, err = 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Single read: req0 reads addr 6'h05; memory returns 16'hA5A5 with ready 2 cycles after valid. Required: mem_valid_o high 2 cycles; ack0 pulses 1 cycle later with req_rdata_o = 16'hA5A5 and err0 = 0.
- Write then read: req1 writes 16'h1234 to 6'h3F (wraps to top address), then reads 6'h3F. Required: mem_wr_rd_o = 1 then 0; read returns 16'h1234; ack1 pulses twice.
- Contention: req0 and req1 both held high for 6 transactions. Required: grant order 0,1,0,1,0,1; each ack exactly 3 cycles apart with immediate ready.
- Timeout: TIMEOUT = 4, memory never ready. Required: mem_valid_o high exactly 4 cycles; ack0 and err0 high together; rdata = 0; next request is arbitrated normally.
- Ready at the boundary: with TIMEOUT = 4, ready arrives in the 4th BUSY cycle. Required: err = 0 and data is captured.
- Reset mid-BUSY: assert rst_i while mem_valid_o = 1. Required: next cycle all outputs are 0 and there is no ack. With both requesters pending after reset, requester 0 is granted first.
